mem_line_arbiter: RTL and testbench

Round-robin arbiter and burst sequencer that shares the single byte-wide main memory between the instruction-cache controller (line reads only) and the data-cache controller (line reads and line write-backs). Each granted request becomes a sequence of byte transfers using the memory's read_mem/write_mem/addr_mem/data_mem protocol. Completion is signalled to the requester with a one-cycle ack and a full assembled line. It sits between the two cache controllers and the main memory in the pipelined core top level.

---
 rtl/mem_line_arbiter_if.sv | 42 ++++
 rtl/mem_line_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_line_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_line_arbiter_if.sv
// Cache-side request/response bundle for mem_line_arbiter.
//
// Purpose: groups the icache and dcache line-request handshakes so the
// arbiter and the two cache controllers share one port.
//
// Signals:
//   i_req / i_addr          icache line-read request, held until i_ack
//   i_ack / i_rdata         one-cycle completion pulse and assembled line
//   d_req / d_we / d_addr   dcache request (d_we=1 write-back, 0 read)
//   d_wdata                 dcache write-back line, byte k at [8k+7:8k]
//   d_ack / d_rdata         one-cycle completion pulse and read line
//
// Modports: master = cache controllers, slave = arbiter.
interface mem_line_arbiter_if #(
    parameter int LINE_BYTES = 4
);
    logic                    i_req;
    logic [15:0]             i_addr;
    logic                    i_ack;
    logic [8*LINE_BYTES-1:0] i_rdata;

    logic                    d_req;
    logic                    d_we;
    logic [15:0]             d_addr;
    logic [8*LINE_BYTES-1:0] d_wdata;
    logic                    d_ack;
    logic [8*LINE_BYTES-1:0] d_rdata;

    modport master (
        output i_req, i_addr,
        input  i_ack, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_rdata
    );

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_rdata
    );
endinterface

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one byte-wide main memory
// between the icache (line reads) and the dcache (line reads/write-backs).
//
// Ports:
//   clk, rst      rising-edge clock; asynchronous active-high reset
//   cache         mem_line_arbiter_if.slave: both requesters' req/ack/data
//   read_mem      memory read strobe (pipelined, data returns one edge later)
//   write_mem     memory write strobe (two cycles per byte, held across bytes)
//   addr_mem      memory byte address = line base | byte counter
//   data_mem      bidirectional memory data; driven only while write_mem=1
//   ready_mem     memory ready; grants happen only while it is high
//   busy          high whenever a transfer is in progress
module mem_line_arbiter #(
    parameter int LINE_BYTES = 4,
    parameter int OFF_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_line_arbiter_if.slave cache,
    output logic              read_mem,
    output logic              write_mem,
    output logic [15:0]       addr_mem,
    inout  wire  [7:0]        data_mem,
    input  logic              ready_mem,
    output logic              busy
);

    localparam int LW = 8 * LINE_BYTES;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_LAST,
        WR_A,
        WR_B,
        DONE
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    state_t           state;
    state_t           state_nx;
    owner_t           owner;
    owner_t           last_owner;
    owner_t           grant_owner;
    logic             grant;
    logic [15:0]      grant_addr;
    logic [15:0]      base;
    logic [OFF_W-1:0] cnt;
    logic             cnt_last;
    logic             capture;
    logic [OFF_W-1:0] cap_idx;
    logic [LW-1:0]    wdata;
    logic [LW-1:0]    line;
    logic [LW-1:0]    line_cap;
    logic [LW-1:0]    i_rdata_q;
    logic [LW-1:0]    d_rdata_q;
    logic [7:0]       wbyte;

    // ------------------------------------------------------------------
    // Arbitration: with both requests pending, the one not served last
    // wins; last_owner resets to the dcache so the icache wins first.
    // ------------------------------------------------------------------
    always_comb begin
        grant = (state == IDLE) && ready_mem && (cache.i_req || cache.d_req);
        if (cache.i_req && cache.d_req)
            grant_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
        else
            grant_owner = cache.d_req ? OWN_D : OWN_I;
        grant_addr = (grant_owner == OWN_D) ? cache.d_addr : cache.i_addr;
    end

    assign cnt_last = (cnt == OFF_W'(LINE_BYTES - 1));
    // Read data lags its address by one edge, so the byte arriving now
    // belongs to the previous counter value (wraps to the last byte in RD_LAST).
    assign cap_idx  = cnt - OFF_W'(1);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // ------------------------------------------------------------------
    // FSM next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a variable unassigned and infers a latch.
        state_nx  = state;
        read_mem  = 1'b0;
        write_mem = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (grant)
                    state_nx = (grant_owner == OWN_D && cache.d_we) ? WR_A : RD;
            end
            RD: begin
                read_mem = 1'b1;
                // Nothing has come back yet on the first RD cycle.
                capture  = (cnt != '0);
                if (cnt_last)
                    state_nx = RD_LAST;
            end
            RD_LAST: begin
                capture  = 1'b1;
                state_nx = DONE;
            end
            WR_A: begin
                write_mem = 1'b1;
                state_nx  = WR_B;
            end
            WR_B: begin
                write_mem = 1'b1;
                state_nx  = cnt_last ? DONE : WR_A;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Line assembly: merge the incoming byte into the line being built.
    always_comb begin
        line_cap = line;
        if (capture)
            line_cap[{cap_idx, 3'b000} +: 8] = data_mem;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_I;
            last_owner <= OWN_D;
            base       <= '0;
            cnt        <= '0;
            wdata      <= '0;
            line       <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            line <= line_cap;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner <= grant_owner;
                        base  <= grant_addr & ~16'(LINE_BYTES - 1);
                        wdata <= cache.d_wdata;
                        cnt   <= '0;
                    end
                end
                RD, WR_B: begin
                    cnt <= cnt + OFF_W'(1);
                end
                RD_LAST: begin
                    // Publish the completed line at the DONE entry edge.
                    if (owner == OWN_I)
                        i_rdata_q <= line_cap;
                    else
                        d_rdata_q <= line_cap;
                end
                DONE: begin
                    last_owner <= owner;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wbyte    = wdata[{cnt, 3'b000} +: 8];
    assign addr_mem = base | {{(16 - OFF_W){1'b0}}, cnt};
    // Bus is released whenever no write is in progress.
    assign data_mem = write_mem ? wbyte : {8{1'bz}};
    assign busy     = (state != IDLE);

    assign cache.i_ack   = (state == DONE) && (owner == OWN_I);
    assign cache.d_ack   = (state == DONE) && (owner == OWN_D);
    assign cache.i_rdata = i_rdata_q;
    assign cache.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Testbench for mem_line_arbiter: byte-wide memory model, two requester
// drivers, and a scoreboard monitor that pops the expected response for
// every ack and checks owner, line data, latency and strobe counts.
module tb_mem_line_arbiter;

    localparam int LB = 4;
    localparam int LW = 8 * LB;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_mem;
    logic        write_mem;
    logic [15:0] addr_mem;
    wire  [7:0]  data_mem;
    logic        ready_mem;
    logic        busy;

    always #5 clk = ~clk;

    mem_line_arbiter_if #(.LINE_BYTES(LB)) cif ();

    mem_line_arbiter #(.LINE_BYTES(LB), .OFF_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cache     (cif.slave),
        .read_mem  (read_mem),
        .write_mem (write_mem),
        .addr_mem  (addr_mem),
        .data_mem  (data_mem),
        .ready_mem (ready_mem),
        .busy      (busy)
    );

    // ------------------------------------------------------------------
    // Memory model: read data appears one edge after the address; a write
    // commits on every edge where write_mem is high.
    // ------------------------------------------------------------------
    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic [7:0] mem_q  = 8'h00;
    logic       mem_oe = 1'b0;

    always @(posedge clk) begin
        if (write_mem)
            mem[addr_mem] <= data_mem;
        mem_oe <= read_mem;
        if (read_mem)
            mem_q <= mem[addr_mem];
    end

    assign data_mem = (mem_oe && !write_mem) ? mem_q : 8'hzz;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        own_d;
        logic        we;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic last_d = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_ack(input logic own_d, input logic we, input logic [31:0] data);
        exp_q.push_back({own_d, we, data});
    endtask

    int   busy_cyc = 0;
    int   rd_cyc   = 0;
    int   wr_cyc   = 0;
    logic prev_i   = 1'b0;
    logic prev_d   = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            busy_cyc = 0;
            rd_cyc   = 0;
            wr_cyc   = 0;
            prev_i   = 1'b0;
            prev_d   = 1'b0;
        end else begin
            if (!busy) begin
                busy_cyc = 0;
                rd_cyc   = 0;
                wr_cyc   = 0;
            end else begin
                busy_cyc++;
                if (read_mem)  rd_cyc++;
                if (write_mem) wr_cyc++;
            end
            check("bus_excl", {31'b0, read_mem & write_mem}, 32'd0);
            if (cif.i_ack || cif.d_ack) begin
                check("ack_excl", {31'b0, cif.i_ack & cif.d_ack}, 32'd0);
                check("ack_busy", {31'b0, busy}, 32'd1);
                check("ack_width", {31'b0, (cif.i_ack & prev_i) | (cif.d_ack & prev_d)}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", {31'b0, cif.d_ack}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_owner", {31'b0, cif.d_ack}, {31'b0, mon_e.own_d});
                    check("ack_latency", busy_cyc, mon_e.we ? 2 * LB + 1 : LB + 2);
                    check("rd_strobes", rd_cyc, mon_e.we ? 0 : LB);
                    check("wr_strobes", wr_cyc, mon_e.we ? 2 * LB : 0);
                    if (!mon_e.we)
                        check("rdata", mon_e.own_d ? cif.d_rdata : cif.i_rdata, mon_e.data);
                end
            end
            prev_i = cif.i_ack;
            prev_d = cif.d_ack;
        end
    end

    // ------------------------------------------------------------------
    // Requester drivers: raise req, hold until own ack (bounded), drop.
    // ------------------------------------------------------------------
    task automatic run_i(input logic [15:0] a);
        int n;
        cif.i_addr = a;
        cif.i_req  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cif.i_ack && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("i_ack_seen", {31'b0, cif.i_ack}, 32'd1);
        cif.i_req = 1'b0;
    endtask

    task automatic run_d(input logic [15:0] a, input logic we, input logic [31:0] wd);
        int n;
        cif.d_addr  = a;
        cif.d_we    = we;
        cif.d_wdata = wd;
        cif.d_req   = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cif.d_ack && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("d_ack_seen", {31'b0, cif.d_ack}, 32'd1);
        cif.d_req = 1'b0;
    endtask

    function automatic logic [31:0] ref_line(input logic [15:0] a);
        logic [15:0] b;
        b = a & 16'hFFFC;
        return {ref_mem[b + 16'd3], ref_mem[b + 16'd2], ref_mem[b + 16'd1], ref_mem[b]};
    endfunction

    task automatic check_mem(input string name, input logic [15:0] a, input logic [31:0] v);
        for (int k = 0; k < LB; k++)
            check(name, {24'b0, mem[a + 16'(k)]}, {24'b0, v[8*k +: 8]});
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int          n;
        int          kind;
        logic [15:0] ia;
        logic [15:0] da;
        logic        dwe;
        logic [31:0] dw;

        rst         = 1'b1;
        ready_mem   = 1'b1;
        cif.i_req   = 1'b0;
        cif.i_addr  = 16'h0000;
        cif.d_req   = 1'b0;
        cif.d_we    = 1'b0;
        cif.d_addr  = 16'h0000;
        cif.d_wdata = '0;

        for (int a = 0; a < 65536; a++) begin
            mem[a]     <= 8'(a * 13 + 7);
            ref_mem[a]  = 8'(a * 13 + 7);
        end
        mem[16'h0040] <= 8'h10; mem[16'h0041] <= 8'h11;
        mem[16'h0042] <= 8'h12; mem[16'h0043] <= 8'h13;
        mem[16'h0080] <= 8'h21; mem[16'h0081] <= 8'h22;
        mem[16'h0082] <= 8'h23; mem[16'h0083] <= 8'h24;
        mem[16'h0200] <= 8'hAA; mem[16'h0201] <= 8'hAA;
        mem[16'h0202] <= 8'hAA; mem[16'h0203] <= 8'hAA;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_read_mem", {31'b0, read_mem}, 32'd0);
        check("rst_write_mem", {31'b0, write_mem}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_acks", {30'b0, cif.i_ack, cif.d_ack}, 32'd0);
        check("rst_addr_mem", {16'b0, addr_mem}, 32'd0);
        check("rst_i_rdata", cif.i_rdata, 32'd0);
        check("rst_d_rdata", cif.d_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Both requests out of reset: icache read first, then dcache write-back
        expect_ack(1'b0, 1'b0, 32'h13121110);
        expect_ack(1'b1, 1'b1, 32'h0);
        fork
            run_i(16'h0042);
            run_d(16'h0100, 1'b1, 32'hDEADBEEF);
        join
        check_mem("wb_bytes", 16'h0100, 32'hDEADBEEF);

        // Read the written line back through the dcache
        expect_ack(1'b1, 1'b0, 32'hDEADBEEF);
        run_d(16'h0101, 1'b0, 32'h0);

        // Both held high across two transfers each: I, D, I, D
        expect_ack(1'b0, 1'b0, 32'h24232221);
        expect_ack(1'b1, 1'b0, 32'hDEADBEEF);
        expect_ack(1'b0, 1'b0, 32'h13121110);
        expect_ack(1'b1, 1'b1, 32'h0);
        fork
            begin
                run_i(16'h0080);
                run_i(16'h0041);
            end
            begin
                run_d(16'h0100, 1'b0, 32'h0);
                run_d(16'h0107, 1'b1, 32'h01020304);
            end
        join
        check_mem("alt_wb_bytes", 16'h0104, 32'h01020304);

        // ready_mem low blocks the grant
        ready_mem = 1'b0;
        expect_ack(1'b0, 1'b0, 32'h13121110);
        fork
            run_i(16'h0040);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("ready_gate", {31'b0, busy}, 32'd0);
                end
                ready_mem = 1'b1;
            end
        join

        // dcache drops req mid-read; icache raised meanwhile waits for DONE
        expect_ack(1'b1, 1'b0, 32'h24232221);
        expect_ack(1'b0, 1'b0, 32'h13121110);
        cif.d_addr = 16'h0081;
        cif.d_we   = 1'b0;
        cif.d_req  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drop_grant", {31'b0, busy}, 32'd1);
        @(negedge clk);
        cif.d_req  = 1'b0;
        cif.d_addr = 16'hFFFF;
        run_i(16'h0040);

        // Reset during WR_B of byte 1
        cif.d_addr  = 16'h0202;
        cif.d_we    = 1'b1;
        cif.d_wdata = 32'h44332211;
        cif.d_req   = 1'b1;
        n = 0;
        while (!(write_mem && addr_mem == 16'h0201) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wr_byte1_seen", {16'b0, addr_mem}, 32'h0201);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_write_mem", {31'b0, write_mem}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_d_ack", {31'b0, cif.d_ack}, 32'd0);
        check("abort_d_rdata", cif.d_rdata, 32'd0);
        check("abort_i_rdata", cif.i_rdata, 32'd0);
        cif.d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        last_d = 1'b1;
        check_mem("partial_line", 16'h0200, 32'hAAAA2211);

        // Normal traffic after the abort
        expect_ack(1'b1, 1'b1, 32'h0);
        run_d(16'h0200, 1'b1, 32'h44332211);
        check("wb_keeps_d_rdata", cif.d_rdata, 32'd0);
        expect_ack(1'b0, 1'b0, 32'h44332211);
        run_i(16'h0203);
        expect_ack(1'b1, 1'b0, 32'h13121110);
        run_d(16'h0040, 1'b0, 32'h0);
        check("i_rdata_hold", cif.i_rdata, 32'h44332211);
        last_d = 1'b1;

        // Mixed traffic on disjoint regions, expected lines from ref_mem
        for (int k = 0; k < 12; k++) begin
            kind = int'($urandom_range(0, 2));
            ia   = 16'h0400 | 16'($urandom_range(0, 15));
            da   = 16'h0500 | 16'($urandom_range(0, 15));
            dwe  = 1'($urandom_range(0, 1));
            dw   = $urandom;
            if (kind == 0) begin
                expect_ack(1'b0, 1'b0, ref_line(ia));
                run_i(ia);
                last_d = 1'b0;
            end else begin
                if (kind == 2 && last_d)
                    expect_ack(1'b0, 1'b0, ref_line(ia));
                expect_ack(1'b1, dwe, dwe ? 32'h0 : ref_line(da));
                if (kind == 2 && !last_d)
                    expect_ack(1'b0, 1'b0, ref_line(ia));
                if (dwe)
                    for (int b = 0; b < LB; b++)
                        ref_mem[(da & 16'hFFFC) + 16'(b)] = dw[8*b +: 8];
                if (kind == 1) begin
                    run_d(da, dwe, dw);
                    last_d = 1'b1;
                end else begin
                    last_d = !last_d;
                    fork
                        run_i(ia);
                        run_d(da, dwe, dw);
                    join
                end
            end
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
